// File: rtl/msm_pkg.sv
// ---------------------------------------------------------------------------
// msm_pkg
// Shared definitions for the multiplier arbiter slice.
//   state_e : controller states (IDLE -> CLEAR -> RUN -> RESP -> IDLE)
//   clog2   : ceiling log2, usable in parameter and port width expressions
// ---------------------------------------------------------------------------
package msm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Smallest n with 2**n >= value; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: grants the first set request at or
// after ptr, wrapping from NREQ-1 back to 0.
//   req   : request vector, one bit per requester
//   ptr   : index that has highest priority this cycle (must be < NREQ)
//   grant : one-hot grant, all zero when no request is set
// ---------------------------------------------------------------------------
module rr_arbiter
    import msm_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant
);

    logic          found;
    logic [PW-1:0] idx;

    // Walk the requesters starting at ptr; the first hit wins and masks the
    // rest of the scan.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// ---------------------------------------------------------------------------
// mul_arbiter
// Shares one external signed multiplier between NREQ requesters. A winner is
// picked round-robin, its operands are registered onto mul_a/mul_b, the
// multiplier is cleared for one cycle, enabled until mul_done (or until
// TIMEOUT run cycles pass), and the result is held on rsp_* until accepted.
//   clk, reset_n          : clock, asynchronous active-low reset
//   req_valid/req_ready   : per-requester handshake (req_ready one-hot/zero)
//   req_a, req_b          : packed signed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready   : result handshake
//   rsp_id, rsp_ab, rsp_err : owner, signed product, timeout flag
//   mul_a, mul_b          : operands to the shared multiplier
//   mul_reset, mul_enable : multiplier clear pulse and run enable
//   mul_ab, mul_done      : multiplier product and completion
// ---------------------------------------------------------------------------
module mul_arbiter
    import msm_pkg::*;
#(
    parameter int WIDTH   = 377,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic                    rsp_valid,
    output logic [clog2(NREQ)-1:0]  rsp_id,
    output logic [2*WIDTH-1:0]      rsp_ab,
    output logic                    rsp_err,
    input  logic                    rsp_ready,
    output logic [WIDTH-1:0]        mul_a,
    output logic [WIDTH-1:0]        mul_b,
    output logic                    mul_reset,
    output logic                    mul_enable,
    input  logic [2*WIDTH-1:0]      mul_ab,
    input  logic                    mul_done
);

    localparam int IDW = clog2(NREQ);
    localparam int CW  = (clog2(TIMEOUT + 1) > 0) ? clog2(TIMEOUT + 1) : 1;

    state_e              state_q;
    logic [IDW-1:0]      rr_ptr_q;
    logic [IDW-1:0]      rr_ptr_d;
    logic [CW-1:0]       cnt_q;
    logic                rsp_valid_q;
    logic [IDW-1:0]      rsp_id_q;
    logic [2*WIDTH-1:0]  rsp_ab_q;
    logic                rsp_err_q;
    logic [WIDTH-1:0]    mul_a_q;
    logic [WIDTH-1:0]    mul_b_q;
    logic                mul_reset_q;
    logic                mul_enable_q;

    logic [NREQ-1:0]     grant;
    logic [IDW-1:0]      win;
    logic [WIDTH-1:0]    win_a;
    logic [WIDTH-1:0]    win_b;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (IDW)
    ) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant)
    );

    // Turn the one-hot grant into an index and the winner's operand slices.
    always_comb begin
        win   = '0;
        win_a = '0;
        win_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                win   = IDW'(i);
                win_a = req_a[i*WIDTH +: WIDTH];
                win_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign rr_ptr_d = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);

    // Grants are only offered while idle; gating with reset_n keeps the
    // accept lines quiet while the block is held in reset.
    assign req_ready = (reset_n && (state_q == IDLE)) ? grant : '0;

    // Controller. RUN counts 0..TIMEOUT-1, so a silent multiplier is given
    // exactly TIMEOUT enabled cycles before the transaction is aborted; a
    // mul_done on the last of those cycles still wins over the abort.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            cnt_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_ab_q     <= '0;
            rsp_err_q    <= 1'b0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            mul_reset_q  <= 1'b1;
            mul_enable_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    mul_reset_q  <= 1'b0;
                    mul_enable_q <= 1'b0;
                    if (|grant) begin
                        mul_a_q     <= win_a;
                        mul_b_q     <= win_b;
                        rsp_id_q    <= win;
                        rr_ptr_q    <= rr_ptr_d;
                        mul_reset_q <= 1'b1;
                        state_q     <= CLEAR;
                    end
                end
                CLEAR: begin
                    mul_reset_q  <= 1'b0;
                    mul_enable_q <= 1'b1;
                    cnt_q        <= '0;
                    state_q      <= RUN;
                end
                RUN: begin
                    if (mul_done) begin
                        rsp_ab_q     <= mul_ab;
                        rsp_err_q    <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        mul_enable_q <= 1'b0;
                        state_q      <= RESP;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        rsp_ab_q     <= '0;
                        rsp_err_q    <= 1'b1;
                        rsp_valid_q  <= 1'b1;
                        mul_enable_q <= 1'b0;
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_ab     = rsp_ab_q;
    assign rsp_err    = rsp_err_q;
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign mul_reset  = mul_reset_q;
    assign mul_enable = mul_enable_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mul_arbiter
// Directed bench for mul_arbiter with a behavioural multiplier and a
// transaction-level reference model that checks every cycle.
// ---------------------------------------------------------------------------
module tb_mul_arbiter;

    localparam int W   = 377;
    localparam int N   = 4;
    localparam int T   = 8;
    localparam int IDW = 2;

    typedef logic [W-1:0]   op_t;
    typedef logic [2*W-1:0] wide_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*W-1:0]    req_a;
    logic [N*W-1:0]    req_b;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    wide_t             rsp_ab;
    logic              rsp_err;
    logic              rsp_ready = 1'b1;
    op_t               mul_a;
    op_t               mul_b;
    logic              mul_reset;
    logic              mul_enable;
    wide_t             mul_ab;
    logic              mul_done;

    op_t               opA [N];
    op_t               opB [N];

    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;

    // Multiplier behaviour: mulLat = k means done on the k-th enabled cycle
    // after a clear; 0 means it never finishes.
    int                mulLat = 1;
    logic              strayDone = 1'b0;
    int                mcnt = 0;

    // Reference model state.
    bit                mBusy = 1'b0;
    bit                sawRst = 1'b0;
    int                mPtr = 0;
    int                mGrantCyc = 0;
    int                mDue = 0;
    int                mId = 0;
    wide_t             mAb;
    bit                mErr;
    op_t               mA;
    op_t               mB;

    mul_arbiter #(
        .WIDTH   (W),
        .NREQ    (N),
        .TIMEOUT (T)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_ab     (rsp_ab),
        .rsp_err    (rsp_err),
        .rsp_ready  (rsp_ready),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_reset  (mul_reset),
        .mul_enable (mul_enable),
        .mul_ab     (mul_ab),
        .mul_done   (mul_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Signed full-width product of two W-bit operands.
    function automatic wide_t sprod(input op_t a, input op_t b);
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sb;
        sa = {{W{a[W-1]}}, a};
        sb = {{W{b[W-1]}}, b};
        return sa * sb;
    endfunction

    // Pack the per-requester operand arrays onto the wide input buses.
    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = opA[i];
            req_b[i*W +: W] = opB[i];
        end
    end

    // Behavioural multiplier: product is always available, done is timed
    // from the last clear.
    always @(posedge clk) begin
        if (mul_reset) mcnt <= 0;
        else if (mul_enable) mcnt <= mcnt + 1;
    end

    assign mul_ab   = sprod(mul_a, mul_b);
    assign mul_done = strayDone | (mul_enable && (mulLat > 0) && (mcnt == mulLat - 1));

    task automatic checkOutput(input string name, input wide_t act, input wide_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic checkCount(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] valid);
        @(posedge clk);
        #1;
        req_valid = valid;
    endtask

    function automatic int oneHotIndex(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Reference model, evaluated mid-cycle. A grant in cycle g gives one
    // clear cycle (g+1), then run cycles until the multiplier finishes on
    // its L-th enabled cycle or TIMEOUT run cycles elapse; the response is
    // due from cycle g+2+min(L,T) and stays until it is accepted.
    always @(negedge clk) begin : refModel
        logic         expReset;
        logic         expEnable;
        logic         expRspV;
        logic [N-1:0] expReady;
        int           w;
        int           idx;
        if (!reset_n) begin
            mBusy  = 1'b0;
            mPtr   = 0;
            sawRst = 1'b1;
        end else begin
            expReset  = sawRst || (mBusy && (cyc == mGrantCyc + 1));
            sawRst    = 1'b0;
            expEnable = mBusy && (cyc >= mGrantCyc + 2) && (cyc < mDue);
            expRspV   = mBusy && (cyc >= mDue);
            checkOutput("mul_reset", wide_t'(mul_reset), wide_t'(expReset));
            checkOutput("mul_enable", wide_t'(mul_enable), wide_t'(expEnable));
            checkOutput("rsp_valid", wide_t'(rsp_valid), wide_t'(expRspV));
            if (expEnable) begin
                checkOutput("mul_a", wide_t'(mul_a), wide_t'(mA));
                checkOutput("mul_b", wide_t'(mul_b), wide_t'(mB));
            end
            if (expRspV) begin
                checkOutput("rsp_id", wide_t'(rsp_id), wide_t'(mId));
                checkOutput("rsp_ab", rsp_ab, mAb);
                checkOutput("rsp_err", wide_t'(rsp_err), wide_t'(mErr));
            end
            expReady = '0;
            w = -1;
            if (!mBusy) begin
                for (int k = 0; k < N; k++) begin
                    idx = (mPtr + k) % N;
                    if (w < 0 && req_valid[idx]) w = idx;
                end
            end
            if (w >= 0) expReady[w] = 1'b1;
            checkOutput("req_ready", wide_t'(req_ready), wide_t'(expReady));
            if (expRspV && rsp_ready) begin
                mBusy = 1'b0;
            end else if (w >= 0) begin
                mBusy     = 1'b1;
                mGrantCyc = cyc;
                mErr      = !(mulLat >= 1 && mulLat <= T);
                mDue      = cyc + 2 + (mErr ? T : mulLat);
                mId       = w;
                mA        = opA[w];
                mB        = opB[w];
                mAb       = mErr ? '0 : sprod(opA[w], opB[w]);
                mPtr      = (w + 1) % N;
            end
        end
    end

    task automatic waitGrant(output int gc);
        gc = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                gc = cyc;
                break;
            end
        end
        checkCount("grant_seen", int'(gc >= 0), 1);
    endtask

    task automatic waitRsp(output int rc);
        rc = -1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                rc = cyc;
                break;
            end
        end
        checkCount("rsp_seen", int'(rc >= 0), 1);
    endtask

    task automatic waitIdle();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!rsp_valid && !mul_enable && !mul_reset) begin
                ok = 1'b1;
                break;
            end
        end
        checkCount("idle_reached", int'(ok), 1);
    endtask

    // Watchdog: stop a stuck run with a visible failure.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios with hand-computed expectations.
    initial begin
        int   got[$];
        int   expOrd[5];
        int   gc;
        int   rc;
        int   nRsp;
        op_t  bigA;
        op_t  bigB;
        wide_t capAb;
        logic [IDW-1:0] capId;
        logic capErr;

        for (int i = 0; i < N; i++) begin
            opA[i] = '0;
            opB[i] = '0;
        end

        // Reset values, with every requester asking while held in reset.
        req_valid = 4'b1111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req_ready", wide_t'(req_ready), wide_t'(0));
        checkOutput("rst_rsp_valid", wide_t'(rsp_valid), wide_t'(0));
        checkOutput("rst_rsp_err", wide_t'(rsp_err), wide_t'(0));
        checkOutput("rst_rsp_id", wide_t'(rsp_id), wide_t'(0));
        checkOutput("rst_rsp_ab", rsp_ab, wide_t'(0));
        checkOutput("rst_mul_a", wide_t'(mul_a), wide_t'(0));
        checkOutput("rst_mul_reset", wide_t'(mul_reset), wide_t'(1));
        checkOutput("rst_mul_enable", wide_t'(mul_enable), wide_t'(0));
        @(posedge clk);
        #1;
        req_valid = '0;
        reset_n   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rel_mul_reset_low", wide_t'(mul_reset), wide_t'(0));

        // Fairness: all four asking continuously.
        for (int i = 0; i < N; i++) begin
            opA[i] = op_t'(10 + i);
            opB[i] = op_t'(3 + 2 * i);
        end
        mulLat    = 2;
        rsp_ready = 1'b1;
        applyStimulus(4'b1111);
        for (int c = 0; c < 200 && got.size() < 5; c++) begin
            @(negedge clk);
            if (req_ready != '0) got.push_back(oneHotIndex(req_ready));
        end
        applyStimulus(4'b0000);
        expOrd = '{0, 1, 2, 3, 0};
        checkCount("fair_count", got.size(), 5);
        for (int i = 0; i < 5; i++) begin
            checkCount("fair_order", (i < got.size()) ? got[i] : -1, expOrd[i]);
        end
        waitIdle();

        // Single request: 123 * -456 with a 5-cycle multiplier.
        opA[2] = op_t'(123);
        opB[2] = -op_t'(456);
        mulLat = 5;
        applyStimulus(4'b0100);
        waitGrant(gc);
        checkOutput("single_grant", wide_t'(req_ready), wide_t'(4'b0100));
        applyStimulus(4'b0000);
        waitRsp(rc);
        checkCount("single_latency", rc - gc, 7);
        checkOutput("single_id", wide_t'(rsp_id), wide_t'(2));
        checkOutput("single_ab", rsp_ab, -wide_t'(56088));
        checkOutput("single_err", wide_t'(rsp_err), wide_t'(0));
        waitIdle();

        // Backpressure: response held for many cycles while others wait.
        opA[1] = op_t'(7);
        opB[1] = -op_t'(9);
        opA[3] = op_t'(21);
        opB[3] = op_t'(2);
        mulLat    = 3;
        rsp_ready = 1'b0;
        applyStimulus(4'b0010);
        waitGrant(gc);
        applyStimulus(4'b1001);
        waitRsp(rc);
        capAb  = rsp_ab;
        capId  = rsp_id;
        capErr = rsp_err;
        checkOutput("bp_ab", capAb, -wide_t'(63));
        checkOutput("bp_id", wide_t'(capId), wide_t'(1));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (i == 4) req_valid = 4'b1000;
            @(negedge clk);
            checkOutput("bp_valid_hold", wide_t'(rsp_valid), wide_t'(1));
            checkOutput("bp_ab_stable", rsp_ab, capAb);
            checkOutput("bp_id_stable", wide_t'(rsp_id), wide_t'(capId));
            checkOutput("bp_err_stable", wide_t'(rsp_err), wide_t'(capErr));
            checkOutput("bp_no_ready", wide_t'(req_ready), wide_t'(0));
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_accept_cycle_valid", wide_t'(rsp_valid), wide_t'(1));
        checkOutput("bp_accept_cycle_no_grant", wide_t'(req_ready), wide_t'(0));
        @(negedge clk);
        checkOutput("bp_after_valid", wide_t'(rsp_valid), wide_t'(0));
        checkOutput("bp_next_grant", wide_t'(req_ready), wide_t'(4'b1000));
        applyStimulus(4'b0000);
        waitIdle();

        // Stray completions while idle must be ignored.
        @(posedge clk);
        #1;
        strayDone = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        strayDone = 1'b0;

        // Timeout: multiplier never completes.
        opA[0] = op_t'(5);
        opB[0] = op_t'(6);
        mulLat = 0;
        applyStimulus(4'b0001);
        waitGrant(gc);
        applyStimulus(4'b0000);
        waitRsp(rc);
        checkCount("to_latency", rc - gc, 2 + T);
        checkOutput("to_err", wide_t'(rsp_err), wide_t'(1));
        checkOutput("to_ab", rsp_ab, wide_t'(0));
        checkOutput("to_id", wide_t'(rsp_id), wide_t'(0));
        waitIdle();

        // Reset in the middle of RUN abandons the transaction.
        opA[1] = op_t'(11);
        opB[1] = op_t'(13);
        mulLat = 0;
        applyStimulus(4'b0010);
        waitGrant(gc);
        applyStimulus(4'b0000);
        repeat (4) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_enable", wide_t'(mul_enable), wide_t'(0));
        checkOutput("mid_rst_mul_reset", wide_t'(mul_reset), wide_t'(1));
        checkOutput("mid_rst_mul_a", wide_t'(mul_a), wide_t'(0));
        checkOutput("mid_rst_mul_b", wide_t'(mul_b), wide_t'(0));
        checkOutput("mid_rst_rsp_id", wide_t'(rsp_id), wide_t'(0));
        checkOutput("mid_rst_rsp_valid", wide_t'(rsp_valid), wide_t'(0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("mid_rel_mul_reset_high", wide_t'(mul_reset), wide_t'(1));
        @(negedge clk);
        checkOutput("mid_rel_mul_reset_low", wide_t'(mul_reset), wide_t'(0));
        nRsp = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid) nRsp++;
        end
        checkCount("mid_rst_no_rsp", nRsp, 0);

        // Full-width signed product, negative second operand.
        bigA   = {1'b0, {47{8'hC3}}};
        bigB   = {1'b0, {47{8'h5A}}};
        opA[3] = bigA;
        opB[3] = -bigB;
        mulLat = 4;
        applyStimulus(4'b1000);
        waitGrant(gc);
        applyStimulus(4'b0000);
        waitRsp(rc);
        checkCount("fw_latency", rc - gc, 6);
        checkOutput("fw_id", wide_t'(rsp_id), wide_t'(3));
        checkOutput("fw_ab", rsp_ab, sprod(bigA, -bigB));
        checkOutput("fw_sign", wide_t'(rsp_ab[2*W-1]), wide_t'(1));
        waitIdle();

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
